// File: rtl/snoop_pkg.sv
// Shared types and constants for the snooping CPU-to-VRAM write queue.
package snoop_pkg;

    localparam logic [13:0] FB_OFFSET = 14'h1380;
    localparam logic [13:0] FB_WORDS  = 14'h2AC0;
    localparam logic [3:0]  TAG_PRI   = 4'hF;
    localparam logic [3:0]  TAG_ALT   = 4'hE;

    typedef enum logic [1:0] {C_IDLE, C_ARMED, C_WAITNEG} cap_state_e;
    typedef enum logic [1:0] {D_IDLE, D_LO, D_HI} drain_state_e;

    typedef struct packed {
        logic        page;
        logic [13:0] off;
        logic        hiEn;
        logic        loEn;
        logic [15:0] data;
    } entry_t;

    localparam int unsigned ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/snoop_write_queue_if.sv
// CPU bus pins seen by the snoop and the VRAM write port it drives.
interface snoop_write_queue_if;

    logic [22:0] cpuAddr;
    logic [15:0] cpuData;
    logic        ncpuAS;
    logic        ncpuUDS;
    logic        ncpuLDS;
    logic        cpuRnW;
    logic [14:0] vramAddr;
    logic        vramPage;
    logic [7:0]  vramDataOut;
    logic        nvramWE;

    modport master (
        output cpuAddr, cpuData, ncpuAS, ncpuUDS, ncpuLDS, cpuRnW,
        input  vramAddr, vramPage, vramDataOut, nvramWE
    );

    modport slave (
        input  cpuAddr, cpuData, ncpuAS, ncpuUDS, ncpuLDS, cpuRnW,
        output vramAddr, vramPage, vramDataOut, nvramWE
    );

endinterface

// File: rtl/snoop_fifo.sv
// Generic synchronous FIFO; a push into a full FIFO succeeds when a pop shares the edge.
module snoop_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PtrW:0] FullCount = (PtrW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  rd_ptr_q, wr_ptr_q;
    logic [PtrW:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign empty   = (count_q == '0);
    assign full    = (count_q == FullCount);
    assign rdata   = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    // The whole pixel domain updates on the falling edge of its clock.
    always_ff @(negedge clk or negedge nReset) begin
        if (!nReset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
        end
    end

    always_ff @(negedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/snoop_write_queue.sv
// Captures 68000 frame-buffer writes into a FIFO and replays them as VRAM byte
// writes in the sequence slots left free by video fetch.
module snoop_write_queue
    import snoop_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned NUM_BUF     = 2,
    parameter int unsigned LAST_WR_SEQ = 5
) (
    input  logic               nReset,
    input  logic               pixClock,
    input  logic [2:0]         seq,
    input  logic [2:0]         ramSize,
    input  logic [NUM_BUF-1:0] bufEnable,
    input  logic               clrOverflow,
    snoop_write_queue_if.slave bus,
    output logic               fifoEmpty,
    output logic               fifoFull,
    output logic               overflow
);

    localparam logic [3:0] LastSeq = 4'(LAST_WR_SEQ);

    logic [3:0]   tag;
    logic [13:0]  off;
    logic         alt_en, hit_pri, hit_alt, selected;
    logic         data_strobe, push_req, pop, drop, can_start, overflow_q;
    cap_state_e   cap_q, cap_d;
    drain_state_e drain_q, drain_d;
    entry_t       cap_entry, head, hold_q;

    generate
        if (NUM_BUF > 1) begin : g_alt
            assign alt_en = bufEnable[1];
        end else begin : g_no_alt
            assign alt_en = 1'b0;
        end
    endgenerate

    assign tag         = bus.cpuAddr[17:14];
    assign off         = bus.cpuAddr[13:0] - FB_OFFSET;
    assign hit_pri     = (tag == TAG_PRI) & bufEnable[0];
    assign hit_alt     = (tag == TAG_ALT) & alt_en;
    assign selected    = (bus.cpuAddr[22:21] == 2'b00) & (bus.cpuAddr[20:18] == ramSize) &
                         (hit_pri | hit_alt) & (off < FB_WORDS);
    assign data_strobe = ~bus.ncpuUDS | ~bus.ncpuLDS;

    always_ff @(negedge pixClock or negedge nReset) begin
        if (!nReset) cap_q <= C_IDLE;
        else         cap_q <= cap_d;
    end

    always_comb begin
        cap_d = cap_q;
        unique case (cap_q)
            C_IDLE:    if (!bus.ncpuAS && selected && !bus.cpuRnW) cap_d = C_ARMED;
            C_ARMED:   if (bus.ncpuAS) cap_d = C_IDLE;
                       else if (data_strobe) cap_d = C_WAITNEG;
            C_WAITNEG: if (bus.ncpuUDS && bus.ncpuLDS) cap_d = C_IDLE;
            default:   cap_d = C_IDLE;
        endcase
    end

    always_comb begin
        push_req       = (cap_q == C_ARMED) & ~bus.ncpuAS & data_strobe;
        cap_entry.page = hit_alt;
        cap_entry.off  = off;
        cap_entry.hiEn = ~bus.ncpuUDS;
        cap_entry.loEn = ~bus.ncpuLDS;
        cap_entry.data = bus.cpuData;
    end

    snoop_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk    (pixClock),
        .nReset (nReset),
        .push   (push_req),
        .wdata  (cap_entry),
        .pop    (pop),
        .rdata  (head),
        .full   (fifoFull),
        .empty  (fifoEmpty)
    );

    // A two-byte entry needs two consecutive write slots, so it must start one slot earlier.
    assign can_start = ~fifoEmpty & ((head.hiEn & head.loEn) ? ({1'b0, seq} < LastSeq)
                                                            : ({1'b0, seq} <= LastSeq));
    assign drop      = push_req & fifoFull & ~pop;
    assign overflow  = overflow_q;

    always_ff @(negedge pixClock or negedge nReset) begin
        if (!nReset)          overflow_q <= 1'b0;
        else if (drop)        overflow_q <= 1'b1;
        else if (clrOverflow) overflow_q <= 1'b0;
    end

    always_ff @(negedge pixClock or negedge nReset) begin
        if (!nReset) begin
            drain_q <= D_IDLE;
            hold_q  <= '0;
        end else begin
            drain_q <= drain_d;
            if (pop) hold_q <= head;
        end
    end

    always_comb begin
        drain_d = drain_q;
        unique case (drain_q)
            D_IDLE:  if (can_start) drain_d = head.loEn ? D_LO : D_HI;
            D_LO:    drain_d = hold_q.hiEn ? D_HI : D_IDLE;
            D_HI:    drain_d = D_IDLE;
            default: drain_d = D_IDLE;
        endcase
    end

    always_comb begin
        pop             = (drain_q == D_IDLE) & can_start;
        bus.nvramWE     = 1'b1;
        bus.vramAddr    = '0;
        bus.vramDataOut = '0;
        bus.vramPage    = 1'b0;
        unique case (drain_q)
            D_LO: begin
                bus.nvramWE     = 1'b0;
                bus.vramAddr    = {hold_q.off, 1'b0};
                bus.vramDataOut = hold_q.data[7:0];
                bus.vramPage    = hold_q.page;
            end
            D_HI: begin
                bus.nvramWE     = 1'b0;
                bus.vramAddr    = {hold_q.off, 1'b1};
                bus.vramDataOut = hold_q.data[15:8];
                bus.vramPage    = hold_q.page;
            end
            default: ;
        endcase
    end

endmodule
